// File: rtl/alu_result_stage.sv
// ============================================================================
// Module   : alu_result_stage
// Function : ALU result FIFO with per-opcode flag qualification, sticky flags
//            and a saturating accepted-operation counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_result_stage #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_opcode,
  input  logic [WIDTH-1:0]           in_result,
  input  logic                       in_carry,
  input  logic                       in_zero,
  input  logic                       in_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_opcode,
  output logic [WIDTH-1:0]           out_result,
  output logic [2:0]                 out_flags,
  output logic [3:0]                 sticky_flags,
  input  logic                       sticky_clear,
  output logic [15:0]                op_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

  logic [3:0]       r_mem_op  [DEPTH];
  logic [WIDTH-1:0] r_mem_res [DEPTH];
  logic [2:0]       r_mem_flg [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_LW-1:0]  r_level;
  logic [3:0]       r_sticky;
  logic [15:0]      r_count;

  logic w_push;
  logic w_pop;
  logic w_arith;
  logic w_illegal;
  logic w_zero;
  logic [2:0] w_flags;
  logic w_unused_zero;

  // The incoming zero flag is superseded by a recomputation from the result.
  assign w_unused_zero = in_zero;

  assign in_ready   = (r_level != c_FULL);
  assign out_valid  = (r_level != '0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;

  assign w_arith    = (in_opcode == 4'd0) || (in_opcode == 4'd1);
  assign w_illegal  = (in_opcode > 4'd5);
  assign w_zero     = (in_result == '0);
  assign w_flags    = {in_overflow & w_arith, in_carry & w_arith, w_zero};

  assign out_opcode   = r_mem_op[r_rptr];
  assign out_result   = r_mem_res[r_rptr];
  assign out_flags    = r_mem_flg[r_rptr];
  assign sticky_flags = r_sticky;
  assign op_count     = r_count;
  assign fifo_level   = r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_op[i]  <= '0;
        r_mem_res[i] <= '0;
        r_mem_flg[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_op[r_wptr]  <= in_opcode;
      r_mem_res[r_wptr] <= in_result;
      r_mem_flg[r_wptr] <= w_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Clear applies before the set, so a coincident push leaves only its flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_count  <= '0;
    end else begin
      r_sticky <= (sticky_clear ? 4'b0000 : r_sticky)
                | (w_push ? {w_illegal, w_flags} : 4'b0000);
      if (w_push && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module   : tb_alu_result_stage
// Function : Directed self-checking bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

  localparam int WIDTH = 128;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_opcode = '0;
  logic [WIDTH-1:0] in_result = '0;
  logic             in_carry = 1'b0;
  logic             in_zero = 1'b0;
  logic             in_overflow = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_opcode;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_flags;
  logic [3:0]       sticky_flags;
  logic             sticky_clear = 1'b0;
  logic [15:0]      op_count;
  logic [2:0]       fifo_level;

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_result(in_result), .in_carry(in_carry), .in_zero(in_zero),
    .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_result(out_result), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .sticky_clear(sticky_clear),
    .op_count(op_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] res;
    logic [2:0]       flg;
  } ent_t;

  ent_t        m_q[$];
  logic [3:0]  m_sticky = '0;
  int          m_count = 0;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference flag rules: arithmetic ops keep carry/overflow, logic ops drop
  // them, unknown ops drop them and are marked illegal; zero comes from result.
  function automatic logic [3:0] model_flags(input logic [3:0] op, input logic [WIDTH-1:0] res,
                                             input logic c, input logic o);
    logic z;
    z = (res == 0);
    if (op <= 1)      return {1'b0, o, c, z};
    else if (op <= 5) return {1'b0, 1'b0, 1'b0, z};
    else              return {1'b1, 1'b0, 1'b0, z};
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("out_valid", WIDTH'(out_valid), WIDTH'(m_q.size() != 0));
      chk("in_ready", WIDTH'(in_ready), WIDTH'(m_q.size() != DEPTH));
      chk("fifo_level", WIDTH'(fifo_level), WIDTH'(m_q.size()));
      chk("sticky", WIDTH'(sticky_flags), WIDTH'(m_sticky));
      chk("op_count", WIDTH'(op_count), WIDTH'(m_count));
      if (m_q.size() != 0) begin
        chk("out_opcode", WIDTH'(out_opcode), WIDTH'(m_q[0].op));
        chk("out_result", out_result, m_q[0].res);
        chk("out_flags", WIDTH'(out_flags), WIDTH'(m_q[0].flg));
      end
    end
  end

  // One cycle: drive at negedge, advance model at posedge, return at next negedge.
  task automatic step(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] res,
                      input logic c, input logic z, input logic o,
                      input logic ordy, input logic clr);
    bit push, pop;
    logic [3:0] f;
    in_valid = v; in_opcode = op; in_result = res;
    in_carry = c; in_zero = z; in_overflow = o;
    out_ready = ordy; sticky_clear = clr;
    push = v && (m_q.size() != DEPTH);
    pop  = ordy && (m_q.size() != 0);
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (clr) m_sticky = 4'b0000;
    if (push) begin
      f = model_flags(op, res, c, o);
      m_q.push_back('{op, res, f[2:0]});
      m_sticky = m_sticky | f;
      if (m_count < 65535) m_count++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst out_valid", WIDTH'(out_valid), '0);
    chk("rst in_ready", WIDTH'(in_ready), WIDTH'(1));
    chk("rst level", WIDTH'(fifo_level), '0);
    chk("rst out_result", out_result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // ADD of zero result with carry
    step(1'b1, 4'd0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add out_flags", WIDTH'(out_flags), WIDTH'(3'b011));
    chk("add sticky", WIDTH'(sticky_flags), WIDTH'(4'b0011));
    chk("add op_count", WIDTH'(op_count), WIDTH'(1));
    idle(1'b1);

    // MUL drops carry/overflow; opcode 9 marks illegal (push+pop at level 1)
    step(1'b1, 4'd5, 128'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mul out_flags", WIDTH'(out_flags), WIDTH'(3'b000));
    step(1'b1, 4'd9, 128'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("illegal sticky", WIDTH'(sticky_flags[3]), WIDTH'(1));
    chk("lvl1 pushpop", WIDTH'(fifo_level), WIDTH'(1));
    idle(1'b1);
    step(1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Five back-to-back pushes into a 4-deep FIFO, then drain
    for (int i = 0; i < 5; i++)
      step(1'b1, 4'(i), WIDTH'(i + 1) << (i * 25), 1'(i & 1), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full level", WIDTH'(fifo_level), WIDTH'(4));
    chk("full in_ready", WIDTH'(in_ready), '0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drained level", WIDTH'(fifo_level), '0);

    // Level 2 push+pop, then full with push+pop requested
    step(1'b1, 4'd1, 128'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 128'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 128'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lvl2 pushpop", WIDTH'(fifo_level), WIDTH'(2));
    chk("lvl2 order", out_result, 128'hB);
    step(1'b1, 4'd4, 128'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 128'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 128'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("full pop only", WIDTH'(fifo_level), WIDTH'(3));
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Sticky clear coinciding with a push
    step(1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'd0, 128'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sticky 0110", WIDTH'(sticky_flags), WIDTH'(4'b0110));
    step(1'b1, 4'd1, 128'h9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear+push", WIDTH'(sticky_flags), WIDTH'(4'b0100));
    idle(1'b1);

    // Sweep all opcodes with alternating consumer readiness
    for (int op = 0; op < 16; op++)
      step(1'b1, 4'(op), (op % 3 == 0) ? '0 : WIDTH'(op * 77), 1'b1, 1'(op & 1), 1'b1, 1'(op & 1), 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Asynchronous reset between edges at level 3
    for (int i = 0; i < 3; i++) step(1'b1, 4'd2, WIDTH'(i + 40), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", WIDTH'(out_valid), '0);
    chk("arst level", WIDTH'(fifo_level), '0);
    chk("arst op_count", WIDTH'(op_count), '0);
    chk("arst sticky", WIDTH'(sticky_flags), '0);
    chk("arst out_opcode", WIDTH'(out_opcode), '0);
    m_q.delete(); m_sticky = '0; m_count = 0;
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("in-reset level", WIDTH'(fifo_level), '0);
    chk("in-reset op_count", WIDTH'(op_count), '0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 4'd3, 128'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post-rst op_count", WIDTH'(op_count), WIDTH'(1));
    idle(1'b1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
